// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
// The master drives valid and data. The slave drives ready.
interface pipe_stage_buffer_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer: a main register plus a one-entry skid register, so in_ready is
// driven from flops and has no combinational dependence on out_ready.
// Flush squashes all held entries into bubbles.
// Optional build macro PIPE_STAGE_STALL_COUNT_EN adds a saturating stall_count output.
module pipe_stage_buffer #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          RESET_DATA = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 flush,
    pipe_stage_buffer_if.slave  upstream,
    pipe_stage_buffer_if.master downstream
`ifdef PIPE_STAGE_STALL_COUNT_EN
    ,
    output logic [15:0]         stall_count
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rst_q;
    logic             main_v, skid_v;
    logic             in_ready;
    logic             accept, emit;

    assign main_v   = (state_q != StEmpty);
    assign skid_v   = (state_q == StTwo);
    // Registered ready: depends only on flops, never on out_ready.
    assign in_ready = ~skid_v & ~rst_q;
    assign accept   = upstream.valid & in_ready;
    assign emit     = main_v & downstream.ready;

    assign upstream.ready   = in_ready;
    assign downstream.valid = main_v;
    assign downstream.data  = main_q;

    // Next-state and datapath selection; flush overrides accept and emit.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            if (RESET_DATA) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = upstream.data;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_d = upstream.data;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = upstream.data;
                    end else if (emit) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only the drain path exists.
                    if (emit) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and storage registers with synchronous reset; reset beats flush.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= StEmpty;
            if (RESET_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STALL_COUNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where the output is held back by downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_v && !downstream.ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB buffers of the 5-stage pipeline.
- Registers one stage's payload on a true clock edge.
- Adds a valid/ready handshake so stalls propagate, a 2-entry skid so ready can be registered, and a synchronous flush that turns in-flight entries into bubbles for branch squash.

Parameters:
- WIDTH, 32: payload width in bits. Legal range 1..256; the ID/EX bundle uses 138.
- RESET_DATA, 1: 1 = storage registers clear to 0 on rst or flush; 0 = data is left unchanged and only the valid bits are cleared.

Ports:
- clk  in  1  stage clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage presents in_data.
- in_ready  out  1  buffer can accept this cycle. Registered.
- in_data  in  WIDTH  upstream payload.
- flush  in  1  squash all held entries (branch taken / hazard bubble).
- out_valid  out  1  out_data holds a live instruction.
- out_ready  in  1  downstream stage consumes out_data this cycle.
- out_data  out  WIDTH  oldest held payload. Driven directly from the main register.

Behaviour:
- Storage:
  - main register (main_q, main_v).
  - skid register (skid_q, skid_v).
  - out_data = main_q; out_valid = main_v; in_ready = ~skid_v & ~rst_q.
- Handshake events:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - No combinational path from out_ready to in_ready.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), TWO (main_v=1, skid_v=1). Transitions, evaluated each rising edge:
  - EMPTY: accept -> ONE, main_q <= in_data. Otherwise stay.
  - ONE:
    - accept & emit -> ONE, main_q <= in_data (back-to-back, full throughput).
    - accept & ~emit -> TWO, skid_q <= in_data.
    - ~accept & emit -> EMPTY.
    - Otherwise hold.
  - TWO: in_ready=0, so accept is impossible.
    - emit -> ONE, main_q <= skid_q.
    - Otherwise hold.
- Latency:
  - Payload accepted at edge N is visible on out_data after edge N (1 cycle) when the buffer was EMPTY or emitting.
  - Order is strictly FIFO.
- Flush has priority over accept and emit:
  - Next state is EMPTY.
  - Data accepted in the flush cycle is dropped.
  - Data clears to 0 if RESET_DATA=1.
  - in_ready=1 on the following cycle.
- Reset:
  - While rst=1: in_ready=0.
  - After the first edge with rst=1: out_valid=0, out_data=0 (RESET_DATA=1), state EMPTY.
  - in_ready=1 on the first cycle after rst deasserts (rst_q register).
  - Reset during TWO discards both entries; no partial emit.
- Stall hold: with out_valid=1 and out_ready=0, out_data must stay bit-stable until emit or flush.
- flush and rst both asserted: rst wins; the result is identical to reset.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: PIPE_STAGE_STALL_COUNT_EN.
- When defined:
  - Adds output stall_count [15:0].
  - It increments on every cycle with out_valid=1 & out_ready=0.
  - It saturates at 16'hFFFF and clears on rst only; flush does not clear it.
- When undefined: the port and counter do not exist. Handshake behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles, in_valid=1 -> in_ready=0, out_valid=0, out_data=0. One cycle after release, in_ready=1.
- Streaming: out_ready=1, push 0x00000011, 0x00000022, 0x00000033 on consecutive cycles -> same values on out_data one cycle later each, out_valid=1 for 3 cycles, in_ready never drops.
- Stall fill: out_ready=0, push 0xAAAA0001 then 0xAAAA0002 -> out_data holds 0xAAAA0001, in_ready=0 after the second accept. Raise out_ready -> 0xAAAA0001 then 0xAAAA0002 emerge in order, in_ready back to 1.
- Flush: state TWO, assert flush with in_valid=1 and in_data=0xDEADBEEF -> next cycle out_valid=0, out_data=0, in_ready=1, 0xDEADBEEF never appears.
- Width: WIDTH=138, push an all-ones payload, then 138'h1 -> both emerge exact with no truncation.
- PIPE_STAGE_STALL_COUNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_count=5. Flush -> still 5. rst -> 0.
